// File: rtl/inst_register_pkg.sv
// Shared defaults, the instruction word type and the power-on instruction table for inst_register.
// The optional write port is enabled with the macro INST_REGISTER_WRITE_EN.
package inst_register_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 16;
    localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

    typedef logic [DATA_W_DEF-1:0] inst_word_t;

    localparam inst_word_t INST_INIT [DEPTH_DEF] = '{
        32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003,
        32'hC0DE_0004, 32'hC0DE_0005, 32'hC0DE_0006, 32'hC0DE_0007,
        32'hC0DE_0008, 32'hC0DE_0009, 32'hC0DE_000A, 32'hC0DE_000B,
        32'hC0DE_000C, 32'hC0DE_000D, 32'hC0DE_000E, 32'hC0DE_000F
    };

    // Entries beyond the table follow the same tag-plus-index pattern.
    function automatic inst_word_t inst_init_word(input int unsigned idx);
        inst_word_t word;
        if (idx < DEPTH_DEF) begin
            word = INST_INIT[idx[ADDR_W_DEF-1:0]];
        end else begin
            word = 32'hC0DE_0000 | idx;
        end
        return word;
    endfunction

endpackage

// File: rtl/inst_register_array.sv
// Instruction storage with combinational read port; ROM of INST_INIT by default,
// writable register file (restored to INST_INIT on reset) when INST_REGISTER_WRITE_EN is defined.
module inst_register_array
    import inst_register_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
`ifdef INST_REGISTER_WRITE_EN
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
`endif
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] entry_w [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
`ifdef INST_REGISTER_WRITE_EN
            logic [DATA_W-1:0] entry_q;

            // Address port is shared with the read side; an address past DEPTH matches no entry.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    entry_q <= DATA_W'(inst_init_word(gi));
                end else if (wr_en && (rd_addr == ADDR_W'(gi))) begin
                    entry_q <= wr_data;
                end
            end

            assign entry_w[gi] = entry_q;
`else
            assign entry_w[gi] = DATA_W'(inst_init_word(gi));
`endif
        end
    endgenerate

    // Unmatched addresses (only possible for non-power-of-two DEPTH) read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data = entry_w[i];
            end
        end
    end

endmodule

// File: rtl/inst_register.sv
// Registered instruction fetch: dataout loads entry[address] on enabled clock edges, cleared by async reset.
// Defining INST_REGISTER_WRITE_EN adds wr_en/wr_data with read-before-write semantics.
module inst_register
    import inst_register_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    output logic [DATA_W-1:0] dataout,
    input  logic              enable,
    input  logic              clock,
    input  logic [ADDR_W-1:0] address,
    input  logic              reset_n
`ifdef INST_REGISTER_WRITE_EN
    ,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data
`endif
);

    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] dataout_q;
    logic [DATA_W-1:0] dataout_d;

    inst_register_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
`ifdef INST_REGISTER_WRITE_EN
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
`endif
        .rd_addr (address),
        .rd_data (rd_data)
    );

    // rd_data reflects pre-edge contents, so a same-edge write is seen only by later reads.
    always_comb begin
        dataout_d = dataout_q;
        if (enable) begin
            dataout_d = rd_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dataout_q <= '0;
        end else begin
            dataout_q <= dataout_d;
        end
    end

    assign dataout = dataout_q;

endmodule

// File: tb/tb_inst_register.sv
// Self-checking bench for inst_register: directed scenarios plus randomized traffic against a reference model.
// Write-port scenarios are included when INST_REGISTER_WRITE_EN is defined.
module tb_inst_register;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [3:0]  address;
    logic [31:0] dataout;
`ifdef INST_REGISTER_WRITE_EN
    logic        wr_en;
    logic [31:0] wr_data;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    int n_txn    = 0;

    logic [31:0] ref_mem [16];
    logic [31:0] ref_out;

    inst_register dut (
        .dataout (dataout),
        .enable  (enable),
        .clock   (clock),
        .address (address),
        .reset_n (reset_n)
`ifdef INST_REGISTER_WRITE_EN
        ,
        .wr_en   (wr_en),
        .wr_data (wr_data)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %h, required %h", tag, got, exp);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 32'hC0DE_0000 + i;
        end
        ref_out = 32'h0;
    endtask

    // One clock edge: update the model with the inputs present at the edge, then compare.
    task automatic tick(input string tag);
        @(posedge clock);
        if (reset_n) begin
            if (enable) ref_out = ref_mem[address];
`ifdef INST_REGISTER_WRITE_EN
            if (wr_en) ref_mem[address] = wr_data;
`endif
        end
        #1;
        n_txn++;
        $display("txn %0d %s en=%0b addr=%0d dout=%h", n_txn, tag, enable, address, dataout);
        check_eq(tag, dataout, ref_out);
    endtask

    // Asynchronous reset pulse placed between edges; dataout must clear without a clock.
    task automatic async_reset_pulse(input string tag);
        #1;
        reset_n = 1'b0;
        #1;
        ref_reset();
        check_eq(tag, dataout, 32'h0);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        address = '0;
`ifdef INST_REGISTER_WRITE_EN
        wr_en   = 1'b0;
        wr_data = '0;
`endif
        ref_reset();
        #2;
        check_eq("reset_dout", dataout, 32'h0);
        // Reads are ignored while reset is held.
        enable  = 1'b1;
        address = 4'd6;
        tick("read_in_reset");
        tick("read_in_reset");
        reset_n = 1'b1;
        enable  = 1'b0;

        // Sweep all addresses on consecutive edges.
        enable = 1'b1;
        for (int a = 0; a < 16; a++) begin
            address = a[3:0];
            tick("sweep");
            check_eq("sweep_const", dataout, 32'hC0DE_0000 | a);
        end

        // Hold with enable low, and inputs changing between edges.
        address = 4'd3;
        tick("read3");
        enable  = 1'b0;
        address = 4'd9;
        #2;
        check_eq("between_edges", dataout, 32'hC0DE_0003);
        tick("hold3");
        check_eq("hold3_const", dataout, 32'hC0DE_0003);

        // Asynchronous reset mid-cycle while holding entry 7.
        enable  = 1'b1;
        address = 4'd7;
        tick("read7");
        check_eq("read7_const", dataout, 32'hC0DE_0007);
        async_reset_pulse("async_reset");
        enable = 1'b0;
        tick("post_reset_hold");

`ifdef INST_REGISTER_WRITE_EN
        // Read-before-write on the same edge.
        enable  = 1'b1;
        wr_en   = 1'b1;
        address = 4'd5;
        wr_data = 32'h1234_5678;
        tick("rbw_old");
        check_eq("rbw_old_const", dataout, 32'hC0DE_0005);
        wr_en = 1'b0;
        tick("rbw_new");
        check_eq("rbw_new_const", dataout, 32'h1234_5678);

        // Reset restores written contents.
        enable  = 1'b0;
        wr_en   = 1'b1;
        address = 4'd2;
        wr_data = 32'hDEAD_BEEF;
        tick("write2");
        wr_en = 1'b0;
        async_reset_pulse("reset_restore");
        enable = 1'b1;
        tick("restore2");
        check_eq("restore2_const", dataout, 32'hC0DE_0002);
`endif

        // Toggling enable: dataout changes only on enabled edges.
        for (int c = 0; c < 16; c++) begin
            enable  = c[0];
            address = 4'($urandom_range(0, 15));
            tick("toggle_en");
        end

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 400; c++) begin
            enable  = 1'($urandom_range(0, 1));
            address = 4'($urandom_range(0, 15));
`ifdef INST_REGISTER_WRITE_EN
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_data = $urandom;
`endif
            tick("random");
            if ($urandom_range(0, 49) == 0) async_reset_pulse("random_reset");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_register.md
INST_REGISTER -- requirements
Module: inst_register

Interface
REQ-001 Parameter DATA_W, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 16, number of instruction entries.
REQ-003 Parameter ADDR_W, default 4, address width; SHALL equal clog2(DEPTH).
REQ-004 Port clock, input, 1 bit: the block's only clock; all state SHALL change on its rising edge.
REQ-005 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port dataout, output, DATA_W bits: registered instruction word.
REQ-007 Port enable, input, 1 bit: read enable, sampled at the rising clock edge.
REQ-008 Port address, input, ADDR_W bits: entry index for read (and write when configured).
REQ-009 Port order SHALL be: dataout, enable, clock, address, reset_n, then any optional ports.

Function
REQ-010 Storage SHALL be DEPTH entries of DATA_W bits each.
REQ-011 At a rising edge with enable=1, dataout SHALL load entry[address]; read latency is exactly 1 cycle.
REQ-012 At a rising edge with enable=0, dataout SHALL hold its previous value.
REQ-013 Every address 0..DEPTH-1 SHALL be valid; no out-of-range case exists for the default DEPTH=16.
REQ-014 For a non-power-of-two DEPTH, a read at address >= DEPTH SHALL load all-zeros.
REQ-015 A change on address or enable between edges SHALL NOT change dataout.
REQ-016 Initial contents SHALL be INST_INIT[i] = 32'hC0DE_0000 | i for i = 0..15.

Reset
REQ-017 reset_n=0 SHALL immediately clear dataout to 0, independent of clock.
REQ-018 reset_n=0 SHALL restore every entry to INST_INIT.
REQ-019 While reset_n=0, reads and writes SHALL be ignored.
REQ-020 Operation SHALL resume at the first rising edge after reset_n rises.
REQ-021 An assertion of reset_n mid-operation SHALL abort any pending write, with no partial update.

Configuration
REQ-022 Macro INST_REGISTER_WRITE_EN, when defined, SHALL add input ports wr_en (1 bit) and wr_data (DATA_W bits).
REQ-023 With INST_REGISTER_WRITE_EN defined, a rising edge with wr_en=1 SHALL write wr_data to entry[address].
REQ-024 With INST_REGISTER_WRITE_EN defined, simultaneous enable=1 and wr_en=1 SHALL return the old entry on dataout (read-before-write); the new value is visible from the next read.
REQ-025 Without INST_REGISTER_WRITE_EN, the wr_en and wr_data ports SHALL be absent and the contents SHALL be constant INST_INIT (ROM behaviour).

Structure
REQ-026 Package inst_register_pkg SHALL hold DATA_W, DEPTH and ADDR_W defaults, the instruction word typedef, and the INST_INIT table.
REQ-027 There SHALL be one sub-module, inst_register_array, holding the storage and write logic; the top level SHALL own the dataout register.

Verification
REQ-028 Reset, then enable=1 with address stepping 0..15 on consecutive edges -> dataout = 32'hC0DE_0000..32'hC0DE_000F, each value one cycle after its address.
REQ-029 Read address 3, then drop enable and change address to 9 -> dataout holds 32'hC0DE_0003.
REQ-030 Assert reset_n=0 between clock edges while dataout = 32'hC0DE_0007 -> dataout = 0 at once, with no clock edge required.
REQ-031 (INST_REGISTER_WRITE_EN) wr_en=1, enable=1, address 5, wr_data 32'h1234_5678 -> dataout = 32'hC0DE_0005 on that edge; the next read of address 5 -> 32'h1234_5678.
REQ-032 (INST_REGISTER_WRITE_EN) Write 32'hDEAD_BEEF to address 2, pulse reset_n, then read address 2 -> dataout = 32'hC0DE_0002.
REQ-033 Alternate enable every cycle, as a toggling-enable bench does, -> dataout updates only on edges where enable=1.
